// File: rtl/sdpram_bist_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : sdpram_bist_engine_if
//  Purpose  : Bundles the BIST control/status signals and both RAM ports.
//             master = test controller side driving start/pat_sel and the
//             RAM read data; slave = the BIST engine.
//  Revision : 1.0  initial release
// ============================================================================
interface sdpram_bist_engine_if #(
   parameter int ADDR_WIDTH    = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int ERR_CNT_WIDTH = 8
);
   logic                     start;
   logic [1:0]               pat_sel;
   logic                     ram_wr_en;
   logic [ADDR_WIDTH-1:0]    ram_wr_addr;
   logic [DATA_WIDTH-1:0]    ram_wr_data;
   logic                     ram_rd_en;
   logic [ADDR_WIDTH-1:0]    ram_rd_addr;
   logic [DATA_WIDTH-1:0]    ram_rd_data;
   logic                     busy;
   logic                     done;
   logic                     pass;
   logic [ERR_CNT_WIDTH-1:0] err_cnt;
   logic                     first_err_vld;
   logic [ADDR_WIDTH-1:0]    first_err_addr;

   modport master (
      output start, pat_sel, ram_rd_data,
      input  ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr,
      input  busy, done, pass, err_cnt, first_err_vld, first_err_addr
   );

   modport slave (
      input  start, pat_sel, ram_rd_data,
      output ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr,
      output busy, done, pass, err_cnt, first_err_vld, first_err_addr
   );
endinterface
`default_nettype wire

// File: rtl/sdpram_bist_engine.sv
`default_nettype none
// ============================================================================
//  Module   : sdpram_bist_engine
//  Purpose  : Built-in self-test for a simple dual-port RAM. Fills every
//             address with a selectable pattern, reads everything back with
//             a 1- or 2-cycle read latency, and reports pass/fail, a
//             saturating error count and the first failing address.
//  Revision : 1.0  initial release
// ============================================================================
module sdpram_bist_engine #(
   parameter int ADDR_WIDTH    = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int RD_LATENCY    = 1,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  wire logic clk,
   input  wire logic rst,
   sdpram_bist_engine_if.slave bus
);

   // Only 1 and 2 are meaningful; anything else behaves as latency 1.
   localparam int                    C_LAT      = (RD_LATENCY == 2) ? 2 : 1;
   localparam logic [ADDR_WIDTH:0]   C_DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   C_CNT_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0]   C_DRAIN    = (ADDR_WIDTH+1)'(C_LAT);
   localparam logic [ERR_CNT_WIDTH-1:0] C_ERR_ONE = ERR_CNT_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_GAP   = 3'd2,
      S_READ  = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [ADDR_WIDTH:0]       r_cnt;
   logic [ADDR_WIDTH:0]       w_cnt_nxt;
   logic [ADDR_WIDTH:0]       w_cnt_inc;
   logic                      w_accept;
   logic [1:0]                r_pat;

   logic                      w_wr_en;
   logic                      w_rd_en;
   logic [ADDR_WIDTH-1:0]     w_addr;
   logic [DATA_WIDTH-1:0]     w_pat_data;

   logic                      r_pipe_vld  [C_LAT];
   logic [ADDR_WIDTH-1:0]     r_pipe_addr [C_LAT];
   logic [DATA_WIDTH-1:0]     r_pipe_exp  [C_LAT];

   logic                      w_mis;
   logic [ERR_CNT_WIDTH-1:0]  w_err_nxt;
   logic [ERR_CNT_WIDTH-1:0]  r_err_cnt;
   logic                      r_first_vld;
   logic [ADDR_WIDTH-1:0]     r_first_addr;
   logic                      r_pass;

   // Pattern generator.
   //   0: all-ones minus address       1: checkerboard (even addr ..AA, odd ..55)
   //   2: address zero-extended/truncated  3: inverse of pattern 2
   function automatic logic [DATA_WIDTH-1:0] f_pattern(
      input logic [1:0]            pat,
      input logic [ADDR_WIDTH-1:0] a
   );
      logic [DATA_WIDTH-1:0] a_ext;
      logic [DATA_WIDTH-1:0] p;
      a_ext = DATA_WIDTH'(a);
      p     = '0;
      case (pat)
         2'd0: p = '1 - a_ext;
         2'd1: begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
               p[i] = a[0] ^ 1'(i % 2);
            end
         end
         2'd2: p = a_ext;
         default: p = ~a_ext;
      endcase
      return p;
   endfunction

   assign w_cnt_inc  = r_cnt + C_CNT_ONE;
   assign w_wr_en    = (r_state == S_WRITE);
   assign w_rd_en    = (r_state == S_READ);
   assign w_addr     = r_cnt[ADDR_WIDTH-1:0];
   assign w_pat_data = f_pattern(r_pat, w_addr);

   // State register and shared address/drain counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic: the counter is one bit wider than the address so the
   // terminal count N is detectable without ever wrapping onto the RAM.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_WRITE;
               w_cnt_nxt   = '0;
            end
         end
         S_WRITE: begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == C_DEPTH) begin
               w_state_nxt = S_GAP;
               w_cnt_nxt   = '0;
            end
         end
         // One idle cycle so the first read never collides with the last write.
         S_GAP: begin
            w_state_nxt = S_READ;
            w_cnt_nxt   = '0;
         end
         S_READ: begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == C_DEPTH) begin
               w_state_nxt = S_DRAIN;
               w_cnt_nxt   = '0;
            end
         end
         S_DRAIN: begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == C_DRAIN) begin
               w_state_nxt = S_DONE;
               w_cnt_nxt   = '0;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Pattern select is captured only with an accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pat <= 2'd0;
      end else if (w_accept) begin
         r_pat <= bus.pat_sel;
      end
   end

   // Expected data, address and valid tag travel alongside the RAM read pipe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < C_LAT; k++) begin
            r_pipe_vld[k]  <= 1'b0;
            r_pipe_addr[k] <= '0;
            r_pipe_exp[k]  <= '0;
         end
      end else begin
         r_pipe_vld[0]  <= w_rd_en;
         r_pipe_addr[0] <= w_addr;
         r_pipe_exp[0]  <= w_pat_data;
         for (int k = 1; k < C_LAT; k++) begin
            r_pipe_vld[k]  <= r_pipe_vld[k-1];
            r_pipe_addr[k] <= r_pipe_addr[k-1];
            r_pipe_exp[k]  <= r_pipe_exp[k-1];
         end
      end
   end

   assign w_mis     = r_pipe_vld[C_LAT-1] && (bus.ram_rd_data != r_pipe_exp[C_LAT-1]);
   assign w_err_nxt = (w_mis && (r_err_cnt != '1)) ? (r_err_cnt + C_ERR_ONE) : r_err_cnt;

   // Result tracking: cleared on accepted start, pass resolved on entry to DONE
   // using the count that already includes the final compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_cnt    <= '0;
         r_first_vld  <= 1'b0;
         r_first_addr <= '0;
         r_pass       <= 1'b0;
      end else if (w_accept) begin
         r_err_cnt    <= '0;
         r_first_vld  <= 1'b0;
         r_first_addr <= '0;
         r_pass       <= 1'b0;
      end else begin
         r_err_cnt <= w_err_nxt;
         if (w_mis && !r_first_vld) begin
            r_first_vld  <= 1'b1;
            r_first_addr <= r_pipe_addr[C_LAT-1];
         end
         if ((r_state == S_DRAIN) && (w_state_nxt == S_DONE)) begin
            r_pass <= (w_err_nxt == '0);
         end
      end
   end

   // RAM-side outputs are forced to zero outside their active phase.
   assign bus.ram_wr_en      = w_wr_en;
   assign bus.ram_wr_addr    = w_wr_en ? w_addr : '0;
   assign bus.ram_wr_data    = w_wr_en ? w_pat_data : '0;
   assign bus.ram_rd_en      = w_rd_en;
   assign bus.ram_rd_addr    = w_rd_en ? w_addr : '0;
   assign bus.busy           = (r_state != S_IDLE) && (r_state != S_DONE);
   assign bus.done           = (r_state == S_DONE);
   assign bus.pass           = r_pass;
   assign bus.err_cnt        = r_err_cnt;
   assign bus.first_err_vld  = r_first_vld;
   assign bus.first_err_addr = r_first_addr;

endmodule
`default_nettype wire
